// File: rtl/adder4bit_rr_seq_if.sv
// adder4bit_rr_seq_if: requester, result and adder-slice signals of the round-robin adder sequencer
interface adder4bit_rr_seq_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_cout, res_id, res_ready;
  logic [W-1:0] res_sum;
  logic [3:0]   add_inA, add_inB, add_s;
  logic         add_cin, add_cout, busy;
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready, add_s, add_cout,
    output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, add_inA, add_inB, add_cin, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready, add_s, add_cout,
    input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, add_inA, add_inB, add_cin, busy
  );
endinterface

// File: rtl/adder4bit_rr_seq.sv
// adder4bit_rr_seq: round-robin sharing of one external 4-bit adder slice, nibble-serial LSB first
module adder4bit_rr_seq #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst,
  adder4bit_rr_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_reg, b_reg, sum_reg, a_sh, b_sh;
  logic carry_reg, id_reg, last_id, gnt_any, gnt_id, take, last, idle, calc, done;
  logic [CW-1:0] cnt;
  logic [CW+1:0] pos;
  always_comb begin
    idle = state == IDLE;
    calc = state == CALC;
    done = state == DONE;
    pos = {cnt, 2'b00};
    last = cnt == CW'(NIBBLES - 1);
    // on a tie the requester that did not own the previous result wins
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt_id = (bus.req0_valid & bus.req1_valid) ? ~last_id : bus.req1_valid;
    bus.req0_ready = idle & gnt_any & ~gnt_id;
    bus.req1_ready = idle & gnt_any & gnt_id;
    take = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
    state_n = idle ? (take ? CALC : IDLE) : calc ? (last ? DONE : CALC) : (bus.res_ready ? IDLE : DONE);
    a_sh = a_reg >> pos;
    b_sh = b_reg >> pos;
    bus.add_inA = calc ? a_sh[3:0] : 4'd0;
    bus.add_inB = calc ? b_sh[3:0] : 4'd0;
    bus.add_cin = calc & carry_reg;
    bus.res_valid = done;
    bus.res_sum = done ? sum_reg : '0;
    bus.res_cout = done & carry_reg;
    bus.res_id = done & id_reg;
    bus.busy = !idle;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      sum_reg <= '0;
      carry_reg <= 1'b0;
      cnt <= '0;
      id_reg <= 1'b0;
      last_id <= 1'b1;
    end else begin
      if (idle && take) begin
        a_reg <= gnt_id ? bus.req1_a : bus.req0_a;
        b_reg <= gnt_id ? bus.req1_b : bus.req0_b;
        id_reg <= gnt_id;
        sum_reg <= '0;
        carry_reg <= 1'b0;
        cnt <= '0;
      end
      // sum_reg starts cleared, so OR-ing each nibble into place is enough
      if (calc) begin
        sum_reg <= sum_reg | (W'(bus.add_s) << pos);
        carry_reg <= bus.add_cout;
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (done && bus.res_ready) last_id <= id_reg;
    end
  end
endmodule

// File: tb/tb_adder4bit_rr_seq.sv
// tb_adder4bit_rr_seq: directed vectors with a result scoreboard for NIBBLES=4 and NIBBLES=1 instances
module tb_adder4bit_rr_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adder4bit_rr_seq_if #(.NIBBLES(4)) b4();
  adder4bit_rr_seq_if #(.NIBBLES(1)) b1();
  adder4bit_rr_seq #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  adder4bit_rr_seq #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  assign {b4.add_cout, b4.add_s} = 5'(b4.add_inA) + 5'(b4.add_inB) + 5'(b4.add_cin);
  assign {b1.add_cout, b1.add_s} = 5'(b1.add_inA) + 5'(b1.add_inB) + 5'(b1.add_cin);
  typedef struct packed {logic id; logic cout; logic [15:0] sum;} exp_t;
  exp_t q4[$];
  logic [5:0] q1[$];
  exp_t e4;
  logic [5:0] e1;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b4.req0_valid && b4.req1_valid) chk("both_ready", 32'(b4.req0_ready & b4.req1_ready), 0);
    if (b4.res_valid && b4.res_ready) begin
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result4: got id %0d sum %0h, none expected", b4.res_id, b4.res_sum);
      end else begin
        e4 = q4.pop_front();
        chk("result4", 32'({b4.res_id, b4.res_cout, b4.res_sum}), 32'(e4));
      end
    end
    if (b1.res_valid && b1.res_ready) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result1: got sum %0h, none expected", b1.res_sum);
      end else begin
        e1 = q1.pop_front();
        chk("result1", 32'({b1.res_id, b1.res_cout, b1.res_sum}), 32'(e1));
      end
    end
  end
  task automatic issue4(input logic id, input logic [15:0] a, input logic [15:0] b, input exp_t e, input logic push);
    int t = 0;
    if (id) begin
      b4.req1_valid = 1'b1; b4.req1_a = a; b4.req1_b = b;
    end else begin
      b4.req0_valid = 1'b1; b4.req0_a = a; b4.req0_b = b;
    end
    @(negedge clk);
    while (!(id ? b4.req1_ready : b4.req0_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept4_timeout", 32'(t < 50), 1);
    if (push) q4.push_back(e);
    @(posedge clk);
    #1;
    if (id) b4.req1_valid = 1'b0;
    else b4.req0_valid = 1'b0;
  endtask
  task automatic issue1(input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    b1.req0_valid = 1'b1; b1.req0_a = a; b1.req0_b = b;
    @(negedge clk);
    while (!b1.req0_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept1_timeout", 32'(t < 50), 1);
    q1.push_back({1'b0, 5'({1'b0, a} + {1'b0, b})});
    @(posedge clk);
    #1;
    b1.req0_valid = 1'b0;
  endtask
  task automatic wait_idle4();
    int t = 0;
    while (b4.busy && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle4_timeout", 32'(t < 50), 1);
  endtask
  initial begin
    int lat, hs, cyc, t;
    logic [3:0] cs, gs;
    b4.req0_valid = 0; b4.req1_valid = 0; b4.req0_a = 0; b4.req0_b = 0; b4.req1_a = 0; b4.req1_b = 0;
    b1.req0_valid = 0; b1.req1_valid = 0; b1.req0_a = 0; b1.req0_b = 0; b1.req1_a = 0; b1.req1_b = 0;
    b4.res_ready = 1; b1.res_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(b4.res_valid), 0);
    chk("rst_busy", 32'(b4.busy), 0);
    chk("rst_res_sum", 32'(b4.res_sum), 0);
    chk("rst_add", 32'({b4.add_inA, b4.add_inB, b4.add_cin}), 0);
    chk("rst_busy1", 32'(b1.busy), 0);
    @(posedge clk);
    #1 rst = 0;
    issue4(0, 16'h1234, 16'h0FFF, {1'b0, 1'b0, 16'h2233}, 1);
    lat = 0;
    while (!b4.res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 4);
    wait_idle4();
    issue4(1, 16'hFFFF, 16'h0001, {1'b1, 1'b1, 16'h0000}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs[i] = b4.add_cin;
    end
    chk("cin_seq", 32'(cs), 32'b1110);
    wait_idle4();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q4.push_back({1'b0, 1'b0, 16'h0002});
    q4.push_back({1'b1, 1'b0, 16'h0020});
    q4.push_back({1'b0, 1'b0, 16'h0002});
    q4.push_back({1'b1, 1'b0, 16'h0020});
    b4.req0_a = 16'h0001; b4.req0_b = 16'h0001; b4.req1_a = 16'h0010; b4.req1_b = 16'h0010;
    b4.req0_valid = 1; b4.req1_valid = 1;
    hs = 0; cyc = 0; gs = 0;
    while (hs < 4 && cyc < 100) begin
      @(negedge clk);
      if (b4.req0_ready) begin gs[hs] = 1'b0; hs++; end
      else if (b4.req1_ready) begin gs[hs] = 1'b1; hs++; end
      @(posedge clk);
      #1;
      cyc++;
    end
    b4.req0_valid = 0; b4.req1_valid = 0;
    chk("rr_handshakes", 32'(hs), 4);
    chk("rr_grant_seq", 32'(gs), 32'b1010);
    wait_idle4();
    b4.res_ready = 0;
    issue4(0, 16'h00FF, 16'h0001, {1'b0, 1'b0, 16'h0100}, 1);
    b4.req1_valid = 1; b4.req1_a = 16'h0003; b4.req1_b = 16'h0004;
    t = 0;
    while (!b4.res_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(b4.res_valid), 1);
      chk("bp_res_sum", 32'(b4.res_sum), 32'h0100);
      chk("bp_res_id", 32'(b4.res_id), 0);
      chk("bp_ready", 32'({b4.req0_ready, b4.req1_ready}), 0);
      chk("bp_busy", 32'(b4.busy), 1);
    end
    @(posedge clk);
    #1;
    q4.push_back({1'b1, 1'b0, 16'h0007});
    b4.res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_busy", 32'(b4.busy), 0);
    chk("bp_release_ready1", 32'(b4.req1_ready), 1);
    @(posedge clk);
    #1 b4.req1_valid = 0;
    wait_idle4();
    issue4(0, 16'h1111, 16'h2222, {1'b0, 1'b0, 16'h3333}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("calc_nibble2", 32'({b4.add_inA, b4.add_inB}), 32'h12);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_busy", 32'(b4.busy), 0);
    chk("abort_res_valid", 32'(b4.res_valid), 0);
    chk("abort_add", 32'({b4.add_inA, b4.add_inB, b4.add_cin}), 0);
    repeat (12) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue1(4'(a), 4'(b));
    t = 0;
    while ((q1.size() != 0 || q4.size() != 0) && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 32'(q1.size() + q4.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
